// File: rtl/micro_sequencer_pkg.sv
// Shared widths and state encoding for the MIC-1 microprogram sequencer.
package micro_sequencer_pkg;

    localparam int MBR_BITS = 8;
    localparam int MPC_BITS = MBR_BITS + 1;
    localparam int CNT_BITS = 32;

    // PAUSE is only reachable when SEQ_SINGLE_STEP_EN is defined.
    typedef enum logic [2:0] {
        INIT     = 3'd0,
        RUN      = 3'd1,
        WAIT_MEM = 3'd2,
        HALT     = 3'd3,
        PAUSE    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// Bundle between control store / datapath (master) and the sequencer (slave).
// Optional single-step inputs exist only with SEQ_SINGLE_STEP_EN defined.
interface micro_sequencer_if;
    import micro_sequencer_pkg::*;

    logic [MPC_BITS-1:0] next_addr;
    logic                jmpc;
    logic                jamn;
    logic                jamz;
    logic                n;
    logic                z;
    logic [MBR_BITS-1:0] mbr;
    logic                mem_req;
    logic                mem_ack;
    logic                halt_req;
    logic [MPC_BITS-1:0] mpc;
    logic                exec_en;
    logic                n_flag;
    logic                z_flag;
    logic                halted;
    logic [CNT_BITS-1:0] ucycles;
`ifdef SEQ_SINGLE_STEP_EN
    logic                step_mode;
    logic                step;

    modport master (
        output next_addr, jmpc, jamn, jamz, n, z, mbr, mem_req, mem_ack, halt_req,
        output step_mode, step,
        input  mpc, exec_en, n_flag, z_flag, halted, ucycles
    );
    modport slave (
        input  next_addr, jmpc, jamn, jamz, n, z, mbr, mem_req, mem_ack, halt_req,
        input  step_mode, step,
        output mpc, exec_en, n_flag, z_flag, halted, ucycles
    );
`else
    modport master (
        output next_addr, jmpc, jamn, jamz, n, z, mbr, mem_req, mem_ack, halt_req,
        input  mpc, exec_en, n_flag, z_flag, halted, ucycles
    );
    modport slave (
        input  next_addr, jmpc, jamn, jamz, n, z, mbr, mem_req, mem_ack, halt_req,
        output mpc, exec_en, n_flag, z_flag, halted, ucycles
    );
`endif

endinterface

// File: rtl/micro_sequencer_next_addr_logic.sv
// Combinational next-MPC computation: JAMN/JAMZ force the top bit,
// JMPC ORs MBR into the low byte of NEXT_ADDRESS.
module next_addr_logic
    import micro_sequencer_pkg::*;
(
    input  logic [MPC_BITS-1:0] next_addr_i,
    input  logic                jmpc_i,
    input  logic                jamn_i,
    input  logic                jamz_i,
    input  logic                n_i,
    input  logic                z_i,
    input  logic [MBR_BITS-1:0] mbr_i,
    output logic [MPC_BITS-1:0] next_mpc_o
);

    // Merge branch conditions and the MBR dispatch into NEXT_ADDRESS.
    always_comb begin
        next_mpc_o = next_addr_i;
        next_mpc_o[MPC_BITS-1] = next_addr_i[MPC_BITS-1] | (jamn_i & n_i) | (jamz_i & z_i);
        if (jmpc_i) begin
            next_mpc_o[MBR_BITS-1:0] = next_addr_i[MBR_BITS-1:0] | mbr_i;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// MIC-1 microprogram sequencer top: state machine, MPC, latched ALU flags,
// executed-microinstruction counter and pending-halt bit.
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds step_mode/step and PAUSE).
module micro_sequencer
    import micro_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    micro_sequencer_if.slave  bus
);

    seq_state_t          state_q, state_d;
    logic [MPC_BITS-1:0] mpc_q, mpc_d;
    logic                n_flag_q, n_flag_d;
    logic                z_flag_q, z_flag_d;
    logic [CNT_BITS-1:0] ucycles_q, ucycles_d;
    logic                halt_pend_q, halt_pend_d;
    logic [MPC_BITS-1:0] next_mpc;

    next_addr_logic u_next_addr (
        .next_addr_i (bus.next_addr),
        .jmpc_i      (bus.jmpc),
        .jamn_i      (bus.jamn),
        .jamz_i      (bus.jamz),
        .n_i         (bus.n),
        .z_i         (bus.z),
        .mbr_i       (bus.mbr),
        .next_mpc_o  (next_mpc)
    );

    // Next-state and register updates; everything holds unless RUN commits.
    always_comb begin
        state_d     = state_q;
        mpc_d       = mpc_q;
        n_flag_d    = n_flag_q;
        z_flag_d    = z_flag_q;
        ucycles_d   = ucycles_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            INIT: begin
                state_d = RUN;
            end
            RUN: begin
                mpc_d     = next_mpc;
                n_flag_d  = bus.n;
                z_flag_d  = bus.z;
                ucycles_d = ucycles_q + CNT_BITS'(1);
                if (bus.mem_req && !bus.mem_ack) begin
                    // Remember the halt so it takes effect once memory completes.
                    state_d     = WAIT_MEM;
                    halt_pend_d = bus.halt_req;
                end else if (bus.halt_req) begin
                    state_d = HALT;
                end else begin
                    state_d = RUN;
`ifdef SEQ_SINGLE_STEP_EN
                    if (bus.step_mode) begin
                        state_d = PAUSE;
                    end
`endif
                end
            end
            WAIT_MEM: begin
                if (bus.mem_ack) begin
                    state_d     = halt_pend_q ? HALT : RUN;
                    halt_pend_d = 1'b0;
                end
            end
            HALT: begin
                state_d = HALT;
            end
`ifdef SEQ_SINGLE_STEP_EN
            PAUSE: begin
                if (bus.step) begin
                    state_d = RUN;
                end
            end
`endif
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State and datapath-control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= INIT;
            mpc_q       <= '0;
            n_flag_q    <= 1'b0;
            z_flag_q    <= 1'b0;
            ucycles_q   <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mpc_q       <= mpc_d;
            n_flag_q    <= n_flag_d;
            z_flag_q    <= z_flag_d;
            ucycles_q   <= ucycles_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign bus.mpc     = mpc_q;
    assign bus.exec_en = (state_q == RUN);
    assign bus.n_flag  = n_flag_q;
    assign bus.z_flag  = z_flag_q;
    assign bus.halted  = (state_q == HALT);
    assign bus.ucycles = ucycles_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: the driver plans microinstruction
// programs, predicts each executed microinstruction's observable state and
// queues it; a monitor pops one entry per exec_en cycle and compares.
module tb_micro_sequencer;
    import micro_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    micro_sequencer_if bus();

    micro_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MPC_BITS-1:0] na;
        bit                  jmpc, jamn, jamz, n, z;
        logic [MBR_BITS-1:0] mbr;
        bit                  mem_req;
        int                  wait_cyc;
        bit                  halt;
        int                  pause;
    } inst_t;

    typedef struct {
        logic [MPC_BITS-1:0] mpc;
        bit                  nf, zf;
        int unsigned         uc;
        int                  gap;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    inst_t       prog[$];
    logic [MPC_BITS-1:0] m_mpc;
    bit          m_n, m_z;
    int unsigned m_k;
    int          m_gap;
    int          idle = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Address the next executed microinstruction must carry.
    function automatic logic [MPC_BITS-1:0] model_next(input inst_t I);
        logic [MPC_BITS-1:0] r;
        r = I.na;
        if ((I.jamn && I.n) || (I.jamz && I.z)) r = r | 9'h100;
        if (I.jmpc) r = r | {1'b0, I.mbr};
        return r;
    endfunction

    function automatic inst_t mk(input logic [MPC_BITS-1:0] na, input bit jmpc, input bit jamn,
                                 input bit jamz, input bit n, input bit z, input logic [MBR_BITS-1:0] mbr,
                                 input bit mem, input int wt, input bit halt);
        inst_t I;
        I.na = na; I.jmpc = jmpc; I.jamn = jamn; I.jamz = jamz; I.n = n; I.z = z;
        I.mbr = mbr; I.mem_req = mem; I.wait_cyc = wt; I.halt = halt; I.pause = 0;
        return I;
    endfunction

    function automatic inst_t rnd_inst();
        inst_t I;
        I.na       = MPC_BITS'($urandom);
        I.jmpc     = ($urandom_range(0, 3) == 0);
        I.jamn     = ($urandom_range(0, 2) == 0);
        I.jamz     = ($urandom_range(0, 2) == 0);
        I.n        = 1'($urandom);
        I.z        = 1'($urandom);
        I.mbr      = MBR_BITS'($urandom);
        I.mem_req  = ($urandom_range(0, 2) == 0);
        I.wait_cyc = I.mem_req ? int'($urandom_range(0, 3)) : 0;
        I.halt     = 1'b0;
        I.pause    = 0;
        return I;
    endfunction

    task automatic drive_random_fields();
        bus.next_addr = MPC_BITS'($urandom);
        bus.jmpc      = 1'($urandom);
        bus.jamn      = 1'($urandom);
        bus.jamz      = 1'($urandom);
        bus.n         = 1'($urandom);
        bus.z         = 1'($urandom);
        bus.mbr       = MBR_BITS'($urandom);
        bus.mem_req   = 1'($urandom);
        bus.mem_ack   = 1'($urandom);
        bus.halt_req  = 1'($urandom);
`ifdef SEQ_SINGLE_STEP_EN
        bus.step      = 1'b0;
`endif
    endtask

    // Present one microinstruction for its RUN cycle, then its stall/pause cycles.
    task automatic drive_inst(input inst_t I, input bit abort);
        exp_t e;
        e.mpc = m_mpc; e.nf = m_n; e.zf = m_z; e.uc = m_k; e.gap = m_gap;
        sb.push_back(e);
        bus.next_addr = I.na;  bus.jmpc = I.jmpc; bus.jamn = I.jamn; bus.jamz = I.jamz;
        bus.n = I.n; bus.z = I.z; bus.mbr = I.mbr; bus.halt_req = I.halt;
        bus.mem_req = I.mem_req;
        bus.mem_ack = I.mem_req ? (I.wait_cyc == 0) : 1'($urandom);
`ifdef SEQ_SINGLE_STEP_EN
        bus.step = 1'b0;
`endif
        m_mpc = model_next(I);
        m_n = I.n; m_z = I.z; m_k++;
        m_gap = (I.mem_req ? I.wait_cyc : 0) + I.pause;
        if (I.mem_req) begin
            for (int j = 0; j < I.wait_cyc; j++) begin
                if (abort && j == 2) return;
                @(negedge clk);
                drive_random_fields();
                bus.mem_ack = (j == I.wait_cyc - 1);
            end
        end
`ifdef SEQ_SINGLE_STEP_EN
        for (int j = 0; j < I.pause; j++) begin
            @(negedge clk);
            drive_random_fields();
            bus.step = (j == I.pause - 1);
        end
`endif
    endtask

    task automatic run_prog(input bit end_with_reset);
        for (int i = 0; i < prog.size(); i++) begin
            @(negedge clk);
            drive_inst(prog[i], end_with_reset && (i == prog.size() - 1));
        end
    endtask

    task automatic halt_check();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_random_fields();
            chk("halt_halted", bus.halted, 1);
            chk("halt_exec_en", bus.exec_en, 0);
            chk("halt_mpc", bus.mpc, m_mpc);
        end
        chk("halt_ucycles", bus.ucycles, m_k);
        chk("halt_n_flag", bus.n_flag, m_n);
        chk("halt_z_flag", bus.z_flag, m_z);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive_random_fields();
        @(negedge clk);
        chk("reset_mpc", bus.mpc, 0);
        chk("reset_exec_en", bus.exec_en, 0);
        chk("reset_halted", bus.halted, 0);
        chk("reset_ucycles", bus.ucycles, 0);
        repeat (2) @(negedge clk);
        chk("reset_n_flag", bus.n_flag, 0);
        chk("reset_z_flag", bus.z_flag, 0);
        reset_n = 1'b1;
        drive_random_fields();
        #1;
        chk("init_exec_en", bus.exec_en, 0);
        m_mpc = '0; m_n = 1'b0; m_z = 1'b0; m_k = 0; m_gap = -1;
    endtask

    // Monitor: one scoreboard entry per cycle in which the DUT commits.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (bus.exec_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_exec: exec_en=1 at mpc %0h, required no execution", bus.mpc);
            end else begin
                e = sb.pop_front();
                chk("exec_mpc", bus.mpc, e.mpc);
                chk("exec_n_flag", bus.n_flag, e.nf);
                chk("exec_z_flag", bus.z_flag, e.zf);
                chk("exec_ucycles", bus.ucycles, e.uc);
                if (e.gap >= 0) chk("stall_gap", idle, e.gap);
            end
            idle = 0;
        end else begin
            idle++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_random_fields();
`ifdef SEQ_SINGLE_STEP_EN
        bus.step_mode = 1'b0;
`endif
        // Directed: branches, dispatch, stalls, zero-wait memory, halt after stall.
        apply_reset();
        prog.delete();
        prog.push_back(mk(9'h012, 0, 0, 1, 0, 1, 8'h00, 0, 0, 0));
        prog.push_back(mk(9'h012, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0));
        prog.push_back(mk(9'h012, 0, 1, 0, 1, 0, 8'h00, 0, 0, 0));
        prog.push_back(mk(9'h100, 1, 0, 0, 1, 1, 8'h5A, 0, 0, 0));
        prog.push_back(mk(9'h033, 0, 0, 0, 0, 1, 8'hFF, 1, 2, 0));
        prog.push_back(mk(9'h044, 0, 0, 1, 1, 0, 8'h00, 1, 0, 0));
        prog.push_back(mk(9'h077, 1, 1, 1, 1, 1, 8'h81, 1, 3, 1));
        run_prog(1'b0);
        halt_check();

        // Directed: reset asserted while waiting on memory.
        apply_reset();
        prog.delete();
        prog.push_back(mk(9'h0A5, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0));
        prog.push_back(mk(9'h1C3, 0, 0, 0, 0, 1, 8'h00, 1, 6, 1));
        run_prog(1'b1);

        // Randomised programs ending in halt or in a reset during a stall.
        for (int ep = 0; ep < 6; ep++) begin
            inst_t last;
            apply_reset();
            prog.delete();
            for (int i = 0; i < int'($urandom_range(20, 40)); i++) prog.push_back(rnd_inst());
            last = rnd_inst();
            if (ep % 2 == 1) begin
                last.mem_req = 1'b1; last.wait_cyc = 6;
            end else begin
                last.halt = 1'b1;
            end
            prog.push_back(last);
            run_prog(ep % 2 == 1);
            if (ep % 2 == 0) halt_check();
        end

`ifdef SEQ_SINGLE_STEP_EN
        // Single-step: one commit per step pulse.
        bus.step_mode = 1'b1;
        apply_reset();
        prog.delete();
        for (int i = 0; i < 8; i++) begin
            inst_t I;
            I = rnd_inst();
            I.mem_req = 1'b0; I.wait_cyc = 0;
            I.pause = int'($urandom_range(1, 3));
            prog.push_back(I);
        end
        prog.push_back(mk(9'h0F0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1));
        run_prog(1'b0);
        halt_check();
        bus.step_mode = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
